mpu_opposite_ctrl: RTL and testbench
====================================

MPU_OPPOSITE_CTRL -- requirements
Module: mpu_opposite_ctrl

Interface
REQ-001 Parameter ELEM_W, default 8: signed element width in bits.
REQ-002 Parameter N_ELEMS, default 25: elements per matrix (5x5).
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port start  input  1  begin a job; sampled only in IDLE.
REQ-006 Port abort  input  1  synchronous abort of the current job.
REQ-007 Port in_valid / in_ready  input / output  1 / 1  element load handshake.
REQ-008 Port in_data  input  ELEM_W  signed operand element.
REQ-009 Port out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-010 Port out_data  output  ELEM_W  signed negated element.
REQ-011 Port out_last  output  1  high with the element at index N_ELEMS-1.
REQ-012 Port busy  output  1  high in every state except IDLE.
REQ-013 Port done  output  1  one-cycle pulse after the last result transfer.
REQ-014 Port overflow  output  1  sticky flag: an element equal to the minimum value (-128) was negated in the current job.

Function
REQ-015 The FSM SHALL have exactly 4 states: IDLE, LOAD, COMPUTE and STREAM.
REQ-016 IDLE: in_ready=0 and out_valid=0; start=1 -> LOAD on the next edge; element index cnt cleared to 0; overflow cleared.
REQ-017 LOAD: in_ready=1; on in_valid&&in_ready, in_data is stored at buffer[cnt] and cnt increments.
REQ-018 LOAD: the transfer with cnt=N_ELEMS-1 -> COMPUTE; cnt wraps to 0.
REQ-019 Element order SHALL be row-major: index k = 5*row + col, with k=0 transferred first on both ports.
REQ-020 COMPUTE SHALL last exactly 1 cycle, replacing every buffer entry with its two's-complement negation (ELEM_W bits).
REQ-021 COMPUTE SHALL set overflow if any entry equals -2^(ELEM_W-1); the entry's result follows REQ-030.
REQ-022 STREAM: out_valid=1, out_data=buffer[cnt], out_last=(cnt==N_ELEMS-1).
REQ-023 STREAM: out_data SHALL be held stable while out_valid=1 and out_ready=0; cnt advances only on out_valid&&out_ready.
REQ-024 The transfer with out_last=1 -> IDLE, with done=1 in the following cycle only.
REQ-025 Minimum latency from start to first out_valid SHALL be N_ELEMS+2 cycles with in_valid held high.
REQ-026 start asserted outside IDLE SHALL be ignored; start and done coinciding in IDLE SHALL start a new job.
REQ-027 abort=1 in any state -> IDLE next edge; cnt=0; no done pulse; overflow holds its value; abort has priority over start and handshakes.
REQ-028 in_valid in IDLE, COMPUTE or STREAM SHALL be ignored (no storage, no in_ready).

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, cnt=0, in_ready=0, out_valid=0, out_last=0, busy=0, done=0, overflow=0, out_data=0, regardless of clk, including mid-LOAD or mid-STREAM; buffer contents are don't-care.

Configuration
REQ-030 Macro MPU_SATURATE_EN: defined -> negating -128 yields +127; undefined -> it yields -128 (wrap); overflow sets in both builds.

Verification
REQ-031 Load 2,-1,0,4,5,12,7,8,9,10,22,12,13,14,15,32,17,18,19,20,45,22,23,24,1, out_ready=1 -> outputs -2,1,0,-4,...,-1 in order; out_last on the 25th; done one cycle later; overflow=0.
REQ-032 Element 0 = -128, others 1 -> overflow=1; first output -128 without MPU_SATURATE_EN, +127 with it.
REQ-033 out_ready toggled 1,0,0,1 during STREAM -> out_data stable in stall cycles; no element skipped or duplicated.
REQ-034 abort after 10 loads, then start and 25 loads of value 3 -> 25 outputs of -3; no done pulse for the aborted job.
REQ-035 rst_n low mid-STREAM, asynchronous to clk -> all outputs at reset values before the next edge; start ignored while busy=1.

Source files
------------

// File: rtl/mpu_opposite_ctrl.sv
// rtl/mpu_opposite_ctrl.sv - element-wise negation engine for a 5x5 signed matrix
//
// Purpose:
//   Loads N_ELEMS signed elements in row-major order, negates all of them in a
//   single COMPUTE cycle, then streams the results out in the same order.
//
// Build option:
//   MPU_SATURATE_EN - when defined, negating the most negative value yields the
//                     most positive value instead of wrapping back to itself.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a job (only honoured in IDLE)
//   abort               synchronous abort, highest priority
//   in_valid/in_ready   element load handshake, in_data is the element
//   out_valid/out_ready result handshake, out_data is the negated element
//   out_last            marks the element at index N_ELEMS-1
//   busy                high in every state except IDLE
//   done                one-cycle pulse after the last result transfer
//   overflow            sticky: the most negative value was negated this job
module mpu_opposite_ctrl #(
    parameter int ELEM_W  = 8,
    parameter int N_ELEMS = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int CNT_W = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_ELEMS - 1);
    localparam logic [ELEM_W-1:0] MIN_VAL  = {1'b1, {(ELEM_W-1){1'b0}}};
    localparam logic [ELEM_W-1:0] MAX_VAL  = {1'b0, {(ELEM_W-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_STREAM  = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [ELEM_W-1:0]  r_out_data;
    logic               r_out_last;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;

    logic [ELEM_W-1:0]  r_buf [N_ELEMS];

    logic [ELEM_W-1:0]  w_neg [N_ELEMS];
    logic               w_any_min;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_load_xfer;
    logic               w_out_xfer;

    // Two's-complement negation at ELEM_W bits; only the most negative value
    // needs special handling, since its true negation is not representable.
    function automatic logic [ELEM_W-1:0] f_neg(input logic [ELEM_W-1:0] x);
        logic [ELEM_W-1:0] v;
        v = ~x + 1'b1;
`ifdef MPU_SATURATE_EN
        if (x == MIN_VAL) begin
            v = MAX_VAL;
        end
`endif
        return v;
    endfunction

    always_comb begin
        w_any_min = 1'b0;
        for (int i = 0; i < N_ELEMS; i++) begin
            w_neg[i] = f_neg(r_buf[i]);
            if (r_buf[i] == MIN_VAL) begin
                w_any_min = 1'b1;
            end
        end
    end

    assign w_cnt_nxt   = r_cnt + 1'b1;
    assign w_load_xfer = (r_state == S_LOAD)   && in_valid  && r_in_ready;
    assign w_out_xfer  = (r_state == S_STREAM) && out_ready && r_out_valid;

    // Operand/result storage. Not reset: its contents are only meaningful
    // after a complete LOAD, which always precedes COMPUTE and STREAM.
    always_ff @(posedge clk) begin
        if (!abort) begin
            if (w_load_xfer) begin
                r_buf[r_cnt] <= in_data;
            end else if (r_state == S_COMPUTE) begin
                for (int i = 0; i < N_ELEMS; i++) begin
                    r_buf[i] <= w_neg[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                // Overflow is deliberately left alone so software can still
                // inspect what the aborted job saw.
                r_state     <= S_IDLE;
                r_cnt       <= '0;
                r_in_ready  <= 1'b0;
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
                r_out_last  <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state    <= S_LOAD;
                            r_cnt      <= '0;
                            r_overflow <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (w_load_xfer) begin
                            if (r_cnt == LAST_IDX) begin
                                r_state    <= S_COMPUTE;
                                r_cnt      <= '0;
                                r_in_ready <= 1'b0;
                            end else begin
                                r_cnt <= w_cnt_nxt;
                            end
                        end
                    end
                    S_COMPUTE: begin
                        // The first result is taken straight from the negation
                        // network so out_data is valid as STREAM begins.
                        r_state     <= S_STREAM;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_neg[0];
                        r_out_last  <= (LAST_IDX == '0);
                        if (w_any_min) begin
                            r_overflow <= 1'b1;
                        end
                    end
                    S_STREAM: begin
                        // out_data only moves on a transfer, so it is held
                        // stable through any out_ready stall.
                        if (w_out_xfer) begin
                            if (r_cnt == LAST_IDX) begin
                                r_state     <= S_IDLE;
                                r_cnt       <= '0;
                                r_out_valid <= 1'b0;
                                r_out_data  <= '0;
                                r_out_last  <= 1'b0;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                            end else begin
                                r_cnt      <= w_cnt_nxt;
                                r_out_data <= r_buf[w_cnt_nxt];
                                r_out_last <= (w_cnt_nxt == LAST_IDX);
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_mpu_opposite_ctrl.sv
// tb/tb_mpu_opposite_ctrl.sv - randomized self-checking bench for mpu_opposite_ctrl
module tb_mpu_opposite_ctrl;

    localparam int ELEM_W  = 8;
    localparam int N_ELEMS = 25;
    localparam int MIN_V   = -128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ELEM_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int vals [N_ELEMS];
    int v31  [N_ELEMS] = '{2, -1, 0, 4, 5, 12, 7, 8, 9, 10, 22, 12, 13, 14, 15,
                           32, 17, 18, 19, 20, 45, 22, 23, 24, 1};

    always #5 clk = ~clk;

    mpu_opposite_ctrl #(.ELEM_W(ELEM_W), .N_ELEMS(N_ELEMS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference negation: mathematical -v, except the one value whose
    // negation does not fit in ELEM_W bits.
    function automatic int exp_neg(input int v);
        if (v == MIN_V) begin
`ifdef MPU_SATURATE_EN
            return 127;
`else
            return MIN_V;
`endif
        end
        return -v;
    endfunction

    function automatic int sdata();
        return int'($signed(out_data));
    endfunction

    task automatic fill_random(input bit allow_min);
        for (int i = 0; i < N_ELEMS; i++) begin
            if (allow_min && $urandom_range(0, 7) == 0) vals[i] = MIN_V;
            else vals[i] = int'($urandom_range(0, 254)) - 127;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_last"}, int'(out_last), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
    endtask

    // Runs one job on vals[]. Entered and left just after a negedge.
    // rdy_mode: 0 out_ready=1, 1 random, 2 repeating 1,0,0,1.
    // kill_phase: 0 none, 1 during load at element kill_at, 2 during stream.
    task automatic run_job(input bit full, input int rdy_mode, input bit chained,
                           input bit chain_next, input int kill_phase,
                           input int kill_at, input bit kill_rst);
        int  k, j, lat, guard, cyc, prev_data;
        bit  ovf, prev_stall;
        ovf = 1'b0;
        for (int i = 0; i < N_ELEMS; i++) if (vals[i] == MIN_V) ovf = 1'b1;
        if (!chained) start = 1'b1;
        lat = 0;
        @(negedge clk); lat++;
        start = 1'b0;
        k = 0; guard = 0;
        while (k < N_ELEMS && guard < 2000) begin
            chk("load_in_ready", int'(in_ready), 1);
            chk("load_busy", int'(busy), 1);
            chk("load_out_valid", int'(out_valid), 0);
            if (kill_phase == 1 && k == kill_at) begin
                in_valid = 1'b0;
                abort = 1'b1; start = 1'b1;
                @(negedge clk);
                abort = 1'b0; start = 1'b0;
                chk("abort_busy", int'(busy), 0);
                chk("abort_in_ready", int'(in_ready), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_ovf_hold", int'(overflow), 0);
                @(negedge clk);
                chk("abort_done_later", int'(done), 0);
                chk("abort_start_ignored", int'(busy), 0);
                return;
            end
            in_valid = full ? 1'b1 : ($urandom_range(0, 2) != 0);
            in_data  = ELEM_W'(vals[k]);
            start    = 1'($urandom_range(0, 1));
            @(posedge clk);
            if (in_valid) k++;
            @(negedge clk); lat++; guard++;
        end
        if (k < N_ELEMS) begin
            chk("load_timeout", k, N_ELEMS);
            return;
        end
        // COMPUTE cycle: nothing is accepted or offered.
        start = 1'b0;
        in_valid = 1'b1;
        chk("compute_in_ready", int'(in_ready), 0);
        chk("compute_out_valid", int'(out_valid), 0);
        chk("compute_busy", int'(busy), 1);
        @(negedge clk); lat++;
        if (full) chk("latency", lat, N_ELEMS + 2);
        j = 0; guard = 0; cyc = 0; prev_stall = 1'b0; prev_data = 0;
        while (j < N_ELEMS && guard < 2000) begin
            chk("out_valid", int'(out_valid), 1);
            chk("in_ready_stream", int'(in_ready), 0);
            chk("out_data", sdata(), exp_neg(vals[j]));
            chk("out_last", int'(out_last), (j == N_ELEMS - 1) ? 1 : 0);
            if (prev_stall) chk("stall_hold", sdata(), prev_data);
            if (j == 0) chk("overflow_stream", int'(overflow), ovf ? 1 : 0);
            if (kill_phase == 2 && j == kill_at) begin
                out_ready = 1'b0; in_valid = 1'b0;
                if (kill_rst) begin
                    #2 rst_n = 1'b0;
                    #1 check_reset_outputs("async_rst");
                    @(negedge clk);
                    rst_n = 1'b1;
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                    chk("post_rst_start_busy", int'(busy), 1);
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("post_rst_abort_busy", int'(busy), 0);
                end else begin
                    abort = 1'b1; start = 1'b1;
                    @(negedge clk);
                    abort = 1'b0; start = 1'b0;
                    chk("sabort_busy", int'(busy), 0);
                    chk("sabort_out_valid", int'(out_valid), 0);
                    chk("sabort_done", int'(done), 0);
                    chk("sabort_ovf_hold", int'(overflow), ovf ? 1 : 0);
                    @(negedge clk);
                    chk("sabort_done_later", int'(done), 0);
                end
                return;
            end
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = ELEM_W'($urandom_range(0, 255));
            start      = 1'($urandom_range(0, 1));
            prev_stall = !out_ready;
            prev_data  = sdata();
            @(posedge clk);
            if (out_ready) j++;
            @(negedge clk); guard++; cyc++;
        end
        if (j < N_ELEMS) begin
            chk("stream_timeout", j, N_ELEMS);
            return;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("done_pulse", int'(done), 1);
        chk("done_busy", int'(busy), 0);
        chk("done_out_valid", int'(out_valid), 0);
        chk("done_overflow", int'(overflow), ovf ? 1 : 0);
        if (chain_next) begin
            start = 1'b1;
            return;
        end
        @(negedge clk);
        chk("done_cleared", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        // Directed row-major sequence, full throughput.
        for (int i = 0; i < N_ELEMS; i++) vals[i] = v31[i];
        run_job(1'b1, 0, 1'b0, 1'b0, 0, 0, 1'b0);

        // Most negative value in element 0.
        vals[0] = MIN_V;
        for (int i = 1; i < N_ELEMS; i++) vals[i] = 1;
        run_job(1'b1, 0, 1'b0, 1'b0, 0, 0, 1'b0);

        // Stall pattern 1,0,0,1 on out_ready.
        fill_random(1'b0);
        run_job(1'b1, 2, 1'b0, 1'b0, 0, 0, 1'b0);

        // Abort after 10 loads, then a job of all 3s.
        fill_random(1'b0);
        run_job(1'b1, 0, 1'b0, 1'b0, 1, 10, 1'b0);
        for (int i = 0; i < N_ELEMS; i++) vals[i] = 3;
        run_job(1'b1, 0, 1'b0, 1'b0, 0, 0, 1'b0);

        // Abort mid-stream after an overflow job, then a clean job.
        fill_random(1'b1);
        vals[5] = MIN_V;
        run_job(1'b1, 1, 1'b0, 1'b0, 2, 7, 1'b0);
        fill_random(1'b0);
        run_job(1'b0, 1, 1'b0, 1'b0, 0, 0, 1'b0);

        // start coinciding with done launches the next job.
        fill_random(1'b1);
        run_job(1'b1, 0, 1'b0, 1'b1, 0, 0, 1'b0);
        fill_random(1'b1);
        run_job(1'b1, 1, 1'b1, 1'b0, 0, 0, 1'b0);

        // Asynchronous reset mid-stream.
        fill_random(1'b1);
        run_job(1'b1, 1, 1'b0, 1'b0, 2, 12, 1'b1);

        // Randomized jobs with input gaps and output back-pressure.
        for (int t = 0; t < 8; t++) begin
            fill_random(1'b1);
            run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                    1'b0, 1'b0, 0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
